// File: rtl/uart_pkg.sv
// Shared definitions for the UART RX command sequencer: opcodes, the
// Gray-coded state encoding and default widths.
package uart_pkg;

  localparam int DEF_DATA_WIDTH     = 8;
  localparam int DEF_ADDR_WIDTH     = 4;
  localparam int DEF_TIMEOUT_CYCLES = 1024;
  localparam int DEF_CNT_WIDTH      = 10;

  localparam logic [7:0] CMD_WRITE = 8'hAA;
  localparam logic [7:0] CMD_READ  = 8'hBB;

  // Gray sequence: every transition along the normal command flow
  // (IDLE->WR_ADDR->WR_DATA, IDLE->RD_ADDR->RD_WAIT->TX_WAIT) flips one bit.
  localparam logic [2:0] ST_IDLE    = 3'b000;
  localparam logic [2:0] ST_WR_ADDR = 3'b001;
  localparam logic [2:0] ST_WR_DATA = 3'b011;
  localparam logic [2:0] ST_RD_ADDR = 3'b010;
  localparam logic [2:0] ST_RD_WAIT = 3'b110;
  localparam logic [2:0] ST_TX_WAIT = 3'b111;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    WR_ADDR = ST_WR_ADDR,
    WR_DATA = ST_WR_DATA,
    RD_ADDR = ST_RD_ADDR,
    RD_WAIT = ST_RD_WAIT,
    TX_WAIT = ST_TX_WAIT
  } state_t;

  // States that wait on the next byte of a command and are guarded by the
  // inter-byte timeout.
  function automatic logic is_timed(state_t s);
    return (s == WR_ADDR) || (s == WR_DATA) || (s == RD_ADDR);
  endfunction

endpackage

// File: rtl/uart_timeout_cnt.sv
// Inter-byte idle counter. Clears on request or while disabled, counts
// while enabled and flags the terminal count TIMEOUT_CYCLES-1.
module uart_timeout_cnt
  import uart_pkg::*;
#(
  parameter int CNT_WIDTH      = DEF_CNT_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic RXFSM_CLK,
  input  logic RXFSM_RST,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CNT_WIDTH-1:0] cnt;

  assign tc = en && (cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

  // Counter register; holds at terminal count so it can never wrap.
  always_ff @(posedge RXFSM_CLK or negedge RXFSM_RST) begin
    if (!RXFSM_RST) begin
      cnt <= '0;
    end else if (clr || !en) begin
      cnt <= '0;
    end else if (!tc) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_cmd_ctrl.sv
// Command sequencer behind the UART RX path: parses AA/addr/data writes
// and BB/addr reads, drives register-file strobes and returns read data
// through the TX path. All outputs are registered.
module uart_rx_cmd_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_WIDTH      = DEF_CNT_WIDTH
) (
  input  logic                  RXFSM_CLK,
  input  logic                  RXFSM_RST,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_DATA_VALID,
  input  logic                  RX_FRAME_ERR,
  output logic                  RF_WR_EN,
  output logic                  RF_RD_EN,
  output logic [ADDR_WIDTH-1:0] RF_ADDR,
  output logic [DATA_WIDTH-1:0] RF_WR_DATA,
  input  logic [DATA_WIDTH-1:0] RF_RD_DATA,
  input  logic                  RF_RD_DATA_VALID,
  output logic [DATA_WIDTH-1:0] TX_P_DATA,
  output logic                  TX_DATA_VALID,
  input  logic                  TX_BUSY,
  output logic                  CMD_ERR
);

  state_t state, state_nxt;
  logic   wr_en_nxt, rd_en_nxt, tx_vld_nxt, err_nxt;
  logic   addr_ld, wr_data_ld, rd_data_ld;
  logic   byte_ok, addr_ok, tmo_tc, tmo_clr, tmo_en;

  assign byte_ok = RX_DATA_VALID && !RX_FRAME_ERR;
  // Only the low ADDR_WIDTH bits of an address byte may be set.
  assign addr_ok = ((RX_P_DATA >> ADDR_WIDTH) == '0);

  // Any byte restarts the idle window, as does entering a waiting state.
  assign tmo_en  = is_timed(state);
  assign tmo_clr = RX_DATA_VALID || (is_timed(state_nxt) && (state_nxt != state));

  uart_timeout_cnt #(
    .CNT_WIDTH      (CNT_WIDTH),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .RXFSM_CLK (RXFSM_CLK),
    .RXFSM_RST (RXFSM_RST),
    .clr       (tmo_clr),
    .en        (tmo_en),
    .tc        (tmo_tc)
  );

  // State register.
  always_ff @(posedge RXFSM_CLK or negedge RXFSM_RST) begin
    if (!RXFSM_RST) state <= IDLE;
    else            state <= state_nxt;
  end

  // Next-state decode and next-cycle strobe values; a byte in the same
  // cycle as the timeout terminal count takes priority.
  always_comb begin
    state_nxt  = state;
    wr_en_nxt  = 1'b0;
    rd_en_nxt  = 1'b0;
    tx_vld_nxt = 1'b0;
    err_nxt    = 1'b0;
    addr_ld    = 1'b0;
    wr_data_ld = 1'b0;
    rd_data_ld = 1'b0;
    case (state)
      IDLE: begin
        if (byte_ok && (RX_P_DATA == DATA_WIDTH'(CMD_WRITE))) begin
          state_nxt = WR_ADDR;
        end else if (byte_ok && (RX_P_DATA == DATA_WIDTH'(CMD_READ))) begin
          state_nxt = RD_ADDR;
        end else if (RX_DATA_VALID) begin
          err_nxt = 1'b1;
        end
      end
      WR_ADDR, RD_ADDR: begin
        if (RX_DATA_VALID) begin
          if (RX_FRAME_ERR || !addr_ok) begin
            state_nxt = IDLE;
            err_nxt   = 1'b1;
          end else begin
            addr_ld = 1'b1;
            if (state == WR_ADDR) begin
              state_nxt = WR_DATA;
            end else begin
              state_nxt = RD_WAIT;
              rd_en_nxt = 1'b1;
            end
          end
        end else if (tmo_tc) begin
          state_nxt = IDLE;
          err_nxt   = 1'b1;
        end
      end
      WR_DATA: begin
        if (RX_DATA_VALID) begin
          state_nxt = IDLE;
          if (RX_FRAME_ERR) begin
            err_nxt = 1'b1;
          end else begin
            wr_en_nxt  = 1'b1;
            wr_data_ld = 1'b1;
          end
        end else if (tmo_tc) begin
          state_nxt = IDLE;
          err_nxt   = 1'b1;
        end
      end
      RD_WAIT: begin
        err_nxt = RX_DATA_VALID;
        if (RF_RD_DATA_VALID) begin
          rd_data_ld = 1'b1;
          state_nxt  = TX_WAIT;
        end
      end
      TX_WAIT: begin
        err_nxt = RX_DATA_VALID;
        if (!TX_BUSY) begin
          tx_vld_nxt = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output strobes and the address/data holding registers.
  always_ff @(posedge RXFSM_CLK or negedge RXFSM_RST) begin
    if (!RXFSM_RST) begin
      RF_WR_EN      <= 1'b0;
      RF_RD_EN      <= 1'b0;
      TX_DATA_VALID <= 1'b0;
      CMD_ERR       <= 1'b0;
      RF_ADDR       <= '0;
      RF_WR_DATA    <= '0;
      TX_P_DATA     <= '0;
    end else begin
      RF_WR_EN      <= wr_en_nxt;
      RF_RD_EN      <= rd_en_nxt;
      TX_DATA_VALID <= tx_vld_nxt;
      CMD_ERR       <= err_nxt;
      if (addr_ld)    RF_ADDR    <= RX_P_DATA[ADDR_WIDTH-1:0];
      if (wr_data_ld) RF_WR_DATA <= RX_P_DATA;
      if (rd_data_ld) TX_P_DATA  <= RF_RD_DATA;
    end
  end

endmodule

// File: tb/tb_uart_rx_cmd_ctrl.sv
// Scoreboard bench for uart_rx_cmd_ctrl: each stimulus byte that should
// produce an output event pushes the expected event (cycle, kind, fields);
// a negedge monitor pops and compares whenever the DUT raises a strobe.
module tb_uart_rx_cmd_ctrl;

  localparam logic [3:0] K_WR  = 4'b0001;
  localparam logic [3:0] K_RD  = 4'b0010;
  localparam logic [3:0] K_TX  = 4'b0100;
  localparam logic [3:0] K_ERR = 4'b1000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_fe = 1'b0;
  logic       rf_wr_en, rf_rd_en, tx_vld, cmd_err;
  logic [3:0] rf_addr;
  logic [7:0] rf_wr_data, tx_data;
  logic [7:0] rf_rd_data = 8'h00;
  logic       rf_rd_vld = 1'b0;
  logic       tx_busy = 1'b0;
  logic [7:0] rf_resp = 8'hE1;

  int cyc = 0;
  int nchk = 0;
  int nfail = 0;
  int rf_cd = 0;

  typedef struct {
    int         cyc;
    logic [3:0] kind;
    logic [3:0] addr;
    logic [7:0] data;
  } exp_t;

  exp_t       sbq[$];
  exp_t       mon_e;
  logic [3:0] mon_obs;

  uart_rx_cmd_ctrl dut (
    .RXFSM_CLK        (clk),
    .RXFSM_RST        (rst_n),
    .RX_P_DATA        (rx_data),
    .RX_DATA_VALID    (rx_valid),
    .RX_FRAME_ERR     (rx_fe),
    .RF_WR_EN         (rf_wr_en),
    .RF_RD_EN         (rf_rd_en),
    .RF_ADDR          (rf_addr),
    .RF_WR_DATA       (rf_wr_data),
    .RF_RD_DATA       (rf_rd_data),
    .RF_RD_DATA_VALID (rf_rd_vld),
    .TX_P_DATA        (tx_data),
    .TX_DATA_VALID    (tx_vld),
    .TX_BUSY          (tx_busy),
    .CMD_ERR          (cmd_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Drive one byte for one cycle; if an event is expected it shows up in
  // the cycle after the valid pulse.
  task automatic send(input logic [7:0] b, input logic fe, input logic [3:0] k,
                      input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    rx_fe    = fe;
    if (k != 4'b0) sbq.push_back('{cyc + 1, k, a, d});
    @(negedge clk);
    rx_valid = 1'b0;
    rx_fe    = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Register-file model: answers a read strobe two cycles later.
  always @(negedge clk) begin
    rf_rd_vld = 1'b0;
    if (rf_cd > 0) begin
      rf_cd = rf_cd - 1;
      if (rf_cd == 0) begin
        rf_rd_vld  = 1'b1;
        rf_rd_data = rf_resp;
      end
    end
    if (rst_n && rf_rd_en) rf_cd = 2;
  end

  // Monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      mon_obs = {cmd_err, tx_vld, rf_rd_en, rf_wr_en};
      if (mon_obs != 4'b0) begin
        if (sbq.size() == 0) begin
          chk("unexpected_event", 32'(mon_obs), 32'h0);
        end else begin
          mon_e = sbq.pop_front();
          chk("event_kind", 32'(mon_obs), 32'(mon_e.kind));
          chk("event_cycle", cyc, mon_e.cyc);
          if (mon_e.kind == K_WR) begin
            chk("wr_addr", 32'(rf_addr), 32'(mon_e.addr));
            chk("wr_data", 32'(rf_wr_data), 32'(mon_e.data));
          end else if (mon_e.kind == K_RD) begin
            chk("rd_addr", 32'(rf_addr), 32'(mon_e.addr));
          end else if (mon_e.kind == K_TX) begin
            chk("tx_data", 32'(tx_data), 32'(mon_e.data));
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got cycle %0d expected finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #2 rst_n = 1'b0;
    #1 chk("reset_outputs", 32'({rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, tx_data, tx_vld, cmd_err}), 32'h0);
    idle(3);
    chk("reset_outputs_clocked", 32'({rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, tx_data, tx_vld, cmd_err}), 32'h0);
    rst_n = 1'b1;
    idle(2);

    // Plain write
    send(8'hAA, 1'b0, 4'b0, 4'h0, 8'h00);
    send(8'h03, 1'b0, 4'b0, 4'h0, 8'h00);
    send(8'h5C, 1'b0, K_WR, 4'h3, 8'h5C);
    idle(3);

    // Read with TX busy; a stray byte during the wait is dropped with an error
    tx_busy = 1'b1;
    rf_resp = 8'hE1;
    send(8'hBB, 1'b0, 4'b0, 4'h0, 8'h00);
    send(8'h07, 1'b0, K_RD, 4'h7, 8'h00);
    idle(6);
    send(8'h33, 1'b0, K_ERR, 4'h0, 8'h00);
    idle(10);
    tx_busy = 1'b0;
    sbq.push_back('{cyc + 1, K_TX, 4'h0, 8'hE1});
    idle(6);

    // Bad opcode, then bad address
    send(8'h12, 1'b0, K_ERR, 4'h0, 8'h00);
    send(8'hAA, 1'b0, 4'b0, 4'h0, 8'h00);
    send(8'h13, 1'b0, K_ERR, 4'h0, 8'h00);
    // A lone data byte afterwards must be treated as an opcode
    send(8'h5C, 1'b0, K_ERR, 4'h0, 8'h00);

    // Frame errors: in IDLE, then on an address byte, then a clean write
    send(8'hAA, 1'b1, K_ERR, 4'h0, 8'h00);
    send(8'hAA, 1'b0, 4'b0, 4'h0, 8'h00);
    send(8'h04, 1'b1, K_ERR, 4'h0, 8'h00);
    send(8'hAA, 1'b0, 4'b0, 4'h0, 8'h00);
    send(8'h04, 1'b0, 4'b0, 4'h0, 8'h00);
    send(8'hFF, 1'b0, K_WR, 4'h4, 8'hFF);
    idle(2);
    chk("tx_data_hold", 32'(tx_data), 32'hE1);

    // Timeout: byte sampled at cycle t, error appears 1024 cycles after
    // the cycle following it
    send(8'hAA, 1'b0, 4'b0, 4'h0, 8'h00);
    send(8'h02, 1'b0, 4'b0, 4'h0, 8'h00);
    sbq.push_back('{cyc + 1024, K_ERR, 4'h0, 8'h00});
    idle(1030);

    // Byte arriving on the terminal-count cycle wins over the timeout
    send(8'hAA, 1'b0, 4'b0, 4'h0, 8'h00);
    send(8'h02, 1'b0, 4'b0, 4'h0, 8'h00);
    idle(1022);
    send(8'h9E, 1'b0, K_WR, 4'h2, 8'h9E);
    idle(3);

    // Reset between address and data of a write
    send(8'hAA, 1'b0, 4'b0, 4'h0, 8'h00);
    send(8'h03, 1'b0, 4'b0, 4'h0, 8'h00);
    #2 rst_n = 1'b0;
    #1 chk("midcmd_reset_outputs", 32'({rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, tx_data, tx_vld, cmd_err}), 32'h0);
    idle(2);
    rst_n = 1'b1;
    send(8'h55, 1'b0, K_ERR, 4'h0, 8'h00);
    idle(5);

    chk("scoreboard_empty", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
